// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: data port has priority over instruction fetch, one outstanding
// memory transaction at a time, aborted with an error after TIMEOUT busy cycles.
module mem_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_done,
   output logic        i_err,
   input  logic        d_req,
   input  logic        d_wr,
   input  logic [1:0]  d_size,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_done,
   output logic        d_err,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        stall
);

   typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

   localparam logic [15:0] LastCnt = 16'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  off_q, off_d;
   logic        mem_req_q, mem_req_d, mem_wr_q, mem_wr_d;
   logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_wstrb_q, mem_wstrb_d;
   logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
   logic        i_done_q, i_done_d, i_err_q, i_err_d;
   logic        d_done_q, d_done_d, d_err_q, d_err_d;
   logic        d_misaligned;
   logic [3:0]  d_strb;
   logic [31:0] d_wrep;

   assign d_misaligned = (d_size == 2'b11) | ((d_size == 2'b01) & d_addr[0]) |
                         ((d_size == 2'b10) & (d_addr[1:0] != 2'b00));

   always_comb begin
      case (d_size)
         2'b00: begin
            d_strb = 4'b0001 << d_addr[1:0];
            d_wrep = {4{d_wdata[7:0]}};
         end
         2'b01: begin
            d_strb = 4'b0011 << {d_addr[1], 1'b0};
            d_wrep = {2{d_wdata[15:0]}};
         end
         default: begin
            d_strb = 4'b1111;
            d_wrep = d_wdata;
         end
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      off_d       = off_q;
      mem_req_d   = mem_req_q;
      mem_wr_d    = mem_wr_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      i_done_d    = 1'b0;
      i_err_d     = 1'b0;
      d_done_d    = 1'b0;
      d_err_d     = 1'b0;
      unique case (state_q)
         StIdle: begin
            // A requester still seeing its own done pulse is not re-sampled.
            if (d_req && !d_done_q) begin
               if (d_misaligned) begin
                  d_done_d = 1'b1;
                  d_err_d  = 1'b1;
               end else begin
                  state_d     = StBusyD;
                  cnt_d       = '0;
                  off_d       = d_addr[1:0];
                  mem_req_d   = 1'b1;
                  mem_wr_d    = d_wr;
                  mem_addr_d  = {d_addr[31:2], 2'b00};
                  mem_wstrb_d = d_wr ? d_strb : 4'b0000;
                  mem_wdata_d = d_wrep;
               end
            end else if (i_req && !i_done_q) begin
               state_d     = StBusyI;
               cnt_d       = '0;
               mem_req_d   = 1'b1;
               mem_wr_d    = 1'b0;
               mem_addr_d  = i_addr & 32'hFFFF_FFFC;
               mem_wstrb_d = 4'b0000;
            end
         end
         StBusyI, StBusyD: begin
            cnt_d = cnt_q + 16'd1;
            if (mem_ready || (cnt_q == LastCnt)) begin
               state_d     = StIdle;
               mem_req_d   = 1'b0;
               mem_wr_d    = 1'b0;
               mem_wstrb_d = 4'b0000;
               if (state_q == StBusyI) begin
                  i_done_d = 1'b1;
                  i_err_d  = !mem_ready;
                  if (mem_ready) i_rdata_d = mem_rdata;
               end else begin
                  d_done_d = 1'b1;
                  d_err_d  = !mem_ready;
                  if (mem_ready && !mem_wr_q) d_rdata_d = mem_rdata >> {off_q, 3'b000};
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         off_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         i_done_q    <= 1'b0;
         i_err_q     <= 1'b0;
         d_done_q    <= 1'b0;
         d_err_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         off_q       <= off_d;
         mem_req_q   <= mem_req_d;
         mem_wr_q    <= mem_wr_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         i_done_q    <= i_done_d;
         i_err_q     <= i_err_d;
         d_done_q    <= d_done_d;
         d_err_q     <= d_err_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_wr    = mem_wr_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign i_done    = i_done_q;
   assign i_err     = i_err_q;
   assign d_done    = d_done_q;
   assign d_err     = d_err_q;
   assign stall     = (i_req & ~i_done_q) | (d_req & ~d_done_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level reference model.
module tb_mem_arbiter;

   localparam int TO = 4;

   logic        clk, resetn;
   logic        i_req, i_done, i_err;
   logic [31:0] i_addr, i_rdata;
   logic        d_req, d_wr, d_done, d_err;
   logic [1:0]  d_size;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        mem_req, mem_wr, mem_ready, stall;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;

   int errs = 0;
   int checks = 0;
   logic [31:0] exp_d = '0;
   logic [31:0] exp_i = '0;

   typedef struct {
      int          lat;
      int          nreq;
      logic        err, wr, pulse2, stall_ok, req_done;
      logic [31:0] addr, wdata, rdata;
      logic [3:0]  strb;
   } obs_t;

   mem_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .resetn(resetn),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_err(i_err),
      .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One transaction on a single port; memory answers in busy cycle dly+1 (never if dly>=TO).
   task automatic xact(input logic is_d, input logic wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rword, input int dly, output obs_t o);
      int   nbusy;
      logic dn;
      o.lat = -1; o.nreq = 0; o.err = 1'b0; o.wr = 1'b0; o.pulse2 = 1'b0;
      o.stall_ok = 1'b1; o.req_done = 1'b0;
      o.addr = '0; o.wdata = '0; o.rdata = '0; o.strb = '0;
      nbusy = 0;
      if (is_d) begin
         d_req = 1'b1; d_wr = wr; d_size = size; d_addr = addr; d_wdata = wdata;
      end else begin
         i_req = 1'b1; i_addr = addr;
      end
      for (int n = 1; n <= 40 && o.lat < 0; n++) begin
         @(posedge clk); #1;
         if (mem_req) begin
            if (nbusy == 0) begin
               o.addr = mem_addr; o.strb = mem_wstrb; o.wdata = mem_wdata; o.wr = mem_wr;
            end
            if (n == 2) begin
               d_addr = ~d_addr; d_wdata = ~d_wdata; i_addr = ~i_addr;
            end
            mem_ready = (nbusy == dly);
            mem_rdata = mem_ready ? rword : $urandom;
            nbusy++;
         end else begin
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
         end
         #4;
         dn = is_d ? d_done : i_done;
         if (stall !== !dn) o.stall_ok = 1'b0;
         if (dn) begin
            o.lat = n; o.err = is_d ? d_err : i_err; o.rdata = is_d ? d_rdata : i_rdata;
            o.req_done = mem_req;
         end
      end
      o.nreq = nbusy;
      @(posedge clk); #1;
      d_req = 1'b0; i_req = 1'b0; mem_ready = 1'b0;
      #4;
      o.pulse2 = i_done | d_done;
   endtask

   task automatic test_reset();
      resetn = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wr = 1'b0; d_size = '0;
      d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({mem_req, mem_wr, mem_wstrb, i_done, i_err, d_done, d_err, stall} !== '0) begin
         errs++;
         $display("FAIL reset_ctrl got req=%b wr=%b strb=%b idn=%b ierr=%b ddn=%b derr=%b st=%b want all 0",
                  mem_req, mem_wr, mem_wstrb, i_done, i_err, d_done, d_err, stall);
      end
      checks++;
      if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== '0) begin
         errs++;
         $display("FAIL reset_data got addr=%h wdata=%h irdata=%h drdata=%h want 0",
                  mem_addr, mem_wdata, i_rdata, d_rdata);
      end
      @(posedge clk); #1;
      resetn = 1'b1;
      #4;
   endtask

   task automatic test_priority();
      d_req = 1'b1; d_wr = 1'b0; d_size = 2'b10; d_addr = 32'h100;
      i_req = 1'b1; i_addr = 32'h0000_0ABD;
      @(posedge clk); #5;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_wr !== 1'b0 || stall !== 1'b1) begin
         errs++;
         $display("FAIL prio_grant got req=%b addr=%h wr=%b stall=%b want 1 00000100 0 1",
                  mem_req, mem_addr, mem_wr, stall);
      end
      @(posedge clk); #1;
      mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
      @(posedge clk); #1;
      mem_ready = 1'b0; mem_rdata = 32'h0;
      #4;
      exp_d = 32'hCAFE_F00D;
      checks++;
      if (d_done !== 1'b1 || d_err !== 1'b0 || d_rdata !== exp_d || i_done !== 1'b0) begin
         errs++;
         $display("FAIL prio_ddone got done=%b err=%b rdata=%h idone=%b want 1 0 %h 0",
                  d_done, d_err, d_rdata, i_done, exp_d);
      end
      @(posedge clk); #1;
      d_req = 1'b0;
      #4;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0ABC || d_done !== 1'b0) begin
         errs++;
         $display("FAIL b2b_fetch got req=%b addr=%h ddone=%b want 1 00000abc 0",
                  mem_req, mem_addr, d_done);
      end
      @(posedge clk); #1;
      mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      #4;
      exp_i = 32'h1234_5678;
      checks++;
      if (i_done !== 1'b1 || i_err !== 1'b0 || i_rdata !== exp_i || mem_req !== 1'b0) begin
         errs++;
         $display("FAIL b2b_idone got done=%b err=%b rdata=%h req=%b want 1 0 %h 0",
                  i_done, i_err, i_rdata, mem_req, exp_i);
      end
      @(posedge clk); #1;
      i_req = 1'b0;
      #4;
   endtask

   task automatic test_directed();
      obs_t o;
      xact(1'b1, 1'b1, 2'b00, 32'h203, 32'h0000_00A5, 32'h0, 1, o);
      checks++;
      if (o.addr !== 32'h200 || o.strb !== 4'b1000 || o.wdata !== 32'hA5A5_A5A5 ||
          o.wr !== 1'b1 || o.err !== 1'b0) begin
         errs++;
         $display("FAIL store_byte got addr=%h strb=%b wdata=%h wr=%b err=%b want 200 1000 a5a5a5a5 1 0",
                  o.addr, o.strb, o.wdata, o.wr, o.err);
      end
      xact(1'b1, 1'b0, 2'b01, 32'h302, 32'h0, 32'h8765_4321, 0, o);
      exp_d = 32'h0000_8765;
      checks++;
      if (o.rdata !== exp_d || o.err !== 1'b0 || o.lat != 2 || o.strb !== 4'b0000) begin
         errs++;
         $display("FAIL load_half got rdata=%h err=%b lat=%0d strb=%b want 00008765 0 2 0000",
                  o.rdata, o.err, o.lat, o.strb);
      end
      xact(1'b1, 1'b0, 2'b10, 32'h401, 32'h0, 32'h0, 0, o);
      checks++;
      if (o.nreq != 0 || o.lat != 1 || o.err !== 1'b1 || o.rdata !== exp_d) begin
         errs++;
         $display("FAIL misalign_word got nreq=%0d lat=%0d err=%b rdata=%h want 0 1 1 %h",
                  o.nreq, o.lat, o.err, o.rdata, exp_d);
      end
      xact(1'b1, 1'b1, 2'b11, 32'h400, 32'h0, 32'h0, 0, o);
      checks++;
      if (o.nreq != 0 || o.lat != 1 || o.err !== 1'b1) begin
         errs++;
         $display("FAIL size11 got nreq=%0d lat=%0d err=%b want 0 1 1", o.nreq, o.lat, o.err);
      end
   endtask

   task automatic test_random_data();
      obs_t        o;
      logic        wr, mis, tout;
      logic [1:0]  sz;
      logic [31:0] a, wd, rw, ew;
      logic [3:0]  es;
      int          dly, off, exp_n;
      for (int k = 0; k < 40; k++) begin
         wr = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         a = $urandom; wd = $urandom; rw = $urandom;
         dly = $urandom_range(0, 5);
         if ($urandom_range(0, 1) == 1) begin
            if (sz == 2'b10) a[1:0] = 2'b00;
            else if (sz == 2'b01) a[0] = 1'b0;
         end
         off  = int'(a[1:0]);
         mis  = (sz == 2'b11) || (sz == 2'b01 && off % 2 == 1) || (sz == 2'b10 && off != 0);
         tout = dly >= TO;
         exp_n = mis ? 0 : (tout ? TO : dly + 1);
         if (sz == 2'b00) begin
            es = 4'(1 << off); ew = {24'h0, wd[7:0]} * 32'h0101_0101;
         end else if (sz == 2'b01) begin
            es = 4'(3 << off); ew = {16'h0, wd[15:0]} * 32'h0001_0001;
         end else begin
            es = 4'hF; ew = wd;
         end
         if (!wr) es = 4'h0;
         if (!mis && !tout && !wr) exp_d = rw >> (8 * off);
         xact(1'b1, wr, sz, a, wd, rw, dly, o);
         checks++;
         if (o.lat != exp_n + 1 || o.nreq != exp_n || o.err !== (mis || tout)) begin
            errs++;
            $display("FAIL rnd_timing k=%0d got lat=%0d nreq=%0d err=%b want %0d %0d %b",
                     k, o.lat, o.nreq, o.err, exp_n + 1, exp_n, mis || tout);
         end
         checks++;
         if (o.pulse2 !== 1'b0 || o.stall_ok !== 1'b1 || o.req_done !== 1'b0) begin
            errs++;
            $display("FAIL rnd_pulse k=%0d got pulse2=%b stall_ok=%b req_at_done=%b want 0 1 0",
                     k, o.pulse2, o.stall_ok, o.req_done);
         end
         checks++;
         if (o.rdata !== exp_d) begin
            errs++;
            $display("FAIL rnd_rdata k=%0d got %h want %h", k, o.rdata, exp_d);
         end
         if (!mis) begin
            checks++;
            if (o.addr !== (a & 32'hFFFF_FFFC) || o.wr !== wr || o.strb !== es ||
                (wr && o.wdata !== ew)) begin
               errs++;
               $display("FAIL rnd_bus k=%0d got addr=%h wr=%b strb=%b wdata=%h want %h %b %b %h",
                        k, o.addr, o.wr, o.strb, o.wdata, a & 32'hFFFF_FFFC, wr, es, ew);
            end
         end
      end
   endtask

   task automatic test_fetch();
      obs_t        o;
      logic [31:0] a, rw;
      int          dly, exp_n;
      logic        tout;
      for (int k = 0; k < 12; k++) begin
         a = $urandom; rw = $urandom;
         dly = (k == 0) ? 99 : $urandom_range(0, 5);
         tout = dly >= TO;
         exp_n = tout ? TO : dly + 1;
         if (!tout) exp_i = rw;
         xact(1'b0, 1'b0, 2'b00, a, 32'h0, rw, dly, o);
         checks++;
         if (o.lat != exp_n + 1 || o.nreq != exp_n || o.err !== tout || o.req_done !== 1'b0) begin
            errs++;
            $display("FAIL fetch_timing k=%0d got lat=%0d nreq=%0d err=%b req=%b want %0d %0d %b 0",
                     k, o.lat, o.nreq, o.err, o.req_done, exp_n + 1, exp_n, tout);
         end
         checks++;
         if (o.addr !== (a & 32'hFFFF_FFFC) || o.strb !== 4'h0 || o.wr !== 1'b0 ||
             o.rdata !== exp_i || o.pulse2 !== 1'b0 || o.stall_ok !== 1'b1) begin
            errs++;
            $display("FAIL fetch_data k=%0d got addr=%h strb=%b wr=%b rdata=%h p2=%b st=%b want %h 0000 0 %h 0 1",
                     k, o.addr, o.strb, o.wr, o.rdata, o.pulse2, o.stall_ok,
                     a & 32'hFFFF_FFFC, exp_i);
         end
      end
   endtask

   task automatic test_reset_busy();
      logic bad;
      d_req = 1'b1; d_wr = 1'b1; d_size = 2'b10; d_addr = 32'h500; d_wdata = 32'h1111_2222;
      @(posedge clk); #1;
      checks++;
      if (mem_req !== 1'b1) begin
         errs++;
         $display("FAIL rstbusy_pre got req=%b want 1", mem_req);
      end
      #1;
      resetn = 1'b0;
      #1;
      exp_d = '0; exp_i = '0;
      checks++;
      if (mem_req !== 1'b0 || mem_wr !== 1'b0 || mem_wstrb !== 4'h0 || mem_addr !== '0 ||
          d_rdata !== exp_d || i_rdata !== exp_i) begin
         errs++;
         $display("FAIL rstbusy_async got req=%b wr=%b strb=%b addr=%h drd=%h ird=%h want 0 0 0 0 0 0",
                  mem_req, mem_wr, mem_wstrb, mem_addr, d_rdata, i_rdata);
      end
      d_req = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      bad = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         mem_ready = 1'b1; mem_rdata = $urandom;
         #4;
         if (d_done || i_done || mem_req) bad = 1'b1;
      end
      mem_ready = 1'b0;
      checks++;
      if (bad !== 1'b0) begin
         errs++;
         $display("FAIL rstbusy_stray got activity=%b want 0", bad);
      end
   endtask

   initial begin
      test_reset();
      test_priority();
      test_directed();
      test_random_data();
      test_fetch();
      test_reset_busy();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum BUSY cycles awaiting mem_ready before abort (legal 2..65535).
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 i_req  input  1  fetch request, held with i_addr until i_done.
REQ-005 i_addr  input  32  fetch byte address.
REQ-006 i_rdata  output  32  fetched word, valid while i_done=1.
REQ-007 i_done, i_err  output  1 each  fetch completion pulse / timeout flag.
REQ-008 d_req, d_wr  input  1 each  data request, write(1)/read(0), held until d_done.
REQ-009 d_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-010 d_addr, d_wdata  input  32 each  data byte address, store data (low-aligned).
REQ-011 d_rdata  output  32  load data shifted right by d_addr[1:0]*8, unextended.
REQ-012 d_done, d_err  output  1 each  data completion pulse / misalign-or-timeout flag.
REQ-013 mem_req, mem_wr  output  1 each  memory request, write qualifier.
REQ-014 mem_addr  output  32  word address, bits[1:0] forced 00.
REQ-015 mem_wstrb  output  4  byte-lane write enables; 0000 on reads.
REQ-016 mem_wdata  output  32  lane-replicated store data.
REQ-017 mem_rdata, mem_ready  input  32, 1  read word; completion strobe.
REQ-018 stall  output  1  (i_req&~i_done)|(d_req&~d_done), combinational.

Function
REQ-019 FSM states IDLE, BUSY_I, BUSY_D; all address/data/strobe outputs registered on grant.
REQ-020 IDLE: d_req wins over i_req when both pending; requester whose done is high this cycle is not sampled.
REQ-021 Misaligned data (half with addr[0]=1, word with addr[1:0]!=0, size 11): no memory access; d_done=d_err=1 next cycle; stay IDLE.
REQ-022 Grant: next cycle enter BUSY_x, mem_req=1; inputs latched at grant, later changes ignored.
REQ-023 Strobes: byte 0001<<addr[1:0]; half 0011<<{addr[1],1'b0}; word 1111; wdata byte {4{b}}, half {2{h}}.
REQ-024 mem_req held 1 throughout BUSY; mem_ready sampled only in BUSY, ignored in IDLE.
REQ-025 mem_ready in BUSY at cycle k: cycle k+1 IDLE, mem_req=0, done=1 for one cycle, rdata registered from mem_rdata.
REQ-026 Minimum latency request-to-done: 3 cycles (grant, mem_ready same cycle as first mem_req, done).
REQ-027 Timeout counter cleared at grant, +1 per BUSY cycle; at TIMEOUT without mem_ready: abort, mem_req=0, done=err=1, IDLE.
REQ-028 In the done cycle the other requester may be granted (back-to-back, no idle bubble).
REQ-029 i_rdata/d_rdata hold last value outside done; i_addr[1:0] ignored.

Reset
REQ-030 resetn=0 immediately forces IDLE, mem_req=0, mem_wr=0, mem_wstrb=0, all done/err=0, counter=0, mem_addr/mem_wdata/rdata=0.
REQ-031 Reset mid-BUSY abandons the transaction; no done issued; subsequent stray mem_ready ignored.

Verification
REQ-032 d_req read word 0x100, i_req same cycle; mem_ready 2 cycles after mem_req -> data granted first, mem_addr=0x100, d_done cycle 4, fetch granted in d_done cycle.
REQ-033 Store byte 0xA5 at 0x203 -> mem_addr=0x200, mem_wstrb=1000, mem_wdata=0xA5A5A5A5, mem_wr=1.
REQ-034 Load half 0x302, mem_rdata=0x8765_4321 -> d_rdata=0x0000_8765, d_err=0.
REQ-035 Word load at 0x401 -> no mem_req, d_done=d_err=1 next cycle; size 11 likewise.
REQ-036 TIMEOUT=4, fetch, no mem_ready -> mem_req high 4 cycles, then i_done=i_err=1, mem_req=0.
REQ-037 resetn low during BUSY_D -> mem_req 0 asynchronously; mem_ready after release produces no done.
